// File: rtl/ahb_lite_bram_slave_pkg.sv
// alpha_ahb_pkg: shared AHB-Lite encodings, the responder FSM state type and
// helpers that turn HSIZE/HADDR[2:0] into byte enables and an alignment flag.
package alpha_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR       = 3'd2,
    S_RD_STALL = 3'd3,
    S_ERR1     = 3'd4,
    S_ERR2     = 3'd5
  } ahb_state_t;

  // 2^hsize consecutive lanes starting at the byte offset. Sizes above a
  // doubleword give an empty mask; they are rejected as illegal anyway.
  function automatic logic [7:0] size_to_be(input logic [2:0] hsize,
                                            input logic [2:0] offset);
    logic [7:0] mask;
    case (hsize)
      HSIZE_BYTE:  mask = 8'h01;
      HSIZE_HALF:  mask = 8'h03;
      HSIZE_WORD:  mask = 8'h0F;
      HSIZE_DWORD: mask = 8'hFF;
      default:     mask = 8'h00;
    endcase
    return mask << offset;
  endfunction

  // True when the byte offset is not a multiple of the transfer size.
  function automatic logic addr_misaligned(input logic [2:0] hsize,
                                           input logic [2:0] offset);
    logic bad;
    case (hsize)
      HSIZE_HALF:  bad = offset[0];
      HSIZE_WORD:  bad = |offset[1:0];
      HSIZE_DWORD: bad = |offset;
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_lite_bram_slave_bram.sv
// bram_1rw_be: single-port 64-bit RAM with per-byte write enables and a
// registered read port, written in the shape block-RAM inference expects.
// Ports:
//   clk_i    clock
//   en_i     port enable (read or write this cycle)
//   we_i     1 = write the enabled lanes, 0 = read into rdata_o
//   be_i     byte enables, lane n = wdata_i[8n+7:8n]
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  registered read data, valid the cycle after a read
module bram_1rw_be #(
  parameter int    DEPTH_LOG2 = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [7:0]            be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [63:0]           wdata_i,
  output logic [63:0]           rdata_o
);

  // Preloading from INIT_FILE is left to the implementation flow's memory
  // initialisation; the simulated array starts unwritten.
  localparam bit unused_init = (INIT_FILE != "");

  logic [63:0] mem [2**DEPTH_LOG2];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int n = 0; n < 8; n++) begin
          if (be_i[n]) mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_lite_bram_slave.sv
// ahb_lite_bram_slave: AHB-Lite responder in front of a 64-bit byte-enabled
// single-port RAM. Reads and writes complete with zero wait states except a
// read whose address phase lands on a write data phase, which takes one.
// Illegal sizes/alignments get a two-cycle ERROR and never touch the RAM.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   HSEL..HREADY      AHB-Lite address/data phase inputs (HBURST ignored)
//   HRDATA            full 64-bit read word
//   HREADYOUT, HRESP  this responder's ready and response
//   dbg_state_o       current FSM state (ahb_state_t encoding)
// Handshake: an address phase is taken when HSEL & HTRANS[1] & HREADY; its
// data phase completes on the first edge where HREADYOUT is 1.
module ahb_lite_bram_slave #(
  parameter int    BRAM_WIDTH = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [63:0] HWDATA,
  input  logic        HREADY,
  output logic [63:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [2:0]  dbg_state_o
);
  import alpha_ahb_pkg::*;

  ahb_state_t state_q, state_d;

  logic [BRAM_WIDTH-1:0] addr_q;
  logic [7:0]            be_q;
  logic [63:0]           hold_q;

  logic [BRAM_WIDTH-1:0] req_addr;
  logic                  accept;
  logic                  illegal;
  logic                  take;

  logic                  ram_en;
  logic                  ram_we;
  logic [BRAM_WIDTH-1:0] ram_addr;
  logic [63:0]           ram_rdata;

  // Upper address bits alias the RAM; burst type and BUSY/IDLE distinction
  // carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{HBURST, HADDR[31:BRAM_WIDTH+3], HTRANS[0]};

  assign req_addr = HADDR[BRAM_WIDTH+2:3];
  assign accept   = HSEL & HTRANS[1] & HREADY;
  assign illegal  = HSIZE[2] | addr_misaligned(HSIZE, HADDR[2:0]);
  // Stall and first error cycle hold HREADY low, so nothing new is taken.
  assign take     = accept && (state_q != S_RD_STALL) && (state_q != S_ERR1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RD_STALL: state_d = S_RD;
      S_ERR1:     state_d = S_ERR2;
      default: begin
        if (take) begin
          if (illegal)              state_d = S_ERR1;
          else if (HWRITE)          state_d = S_WR;
          else if (state_q == S_WR) state_d = S_RD_STALL;
          else                      state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= 64'h0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RD) hold_q <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (take && !illegal) begin
      addr_q <= req_addr;
      be_q   <= size_to_be(HSIZE, HADDR[2:0]);
    end
  end

  // The port belongs to the write data phase in S_WR and to the deferred
  // read in S_RD_STALL; otherwise it serves a read straight from the bus.
  // Reset suppresses a write whose data phase is in flight.
  always_comb begin
    ram_we   = (state_q == S_WR) && !reset;
    ram_addr = req_addr;
    ram_en   = take && !illegal && !HWRITE && (state_q != S_WR);
    if (state_q == S_WR || state_q == S_RD_STALL) begin
      ram_addr = addr_q;
      ram_en   = ram_we || (state_q == S_RD_STALL);
    end
  end

  bram_1rw_be #(
    .DEPTH_LOG2 (BRAM_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (be_q),
    .addr_i  (ram_addr),
    .wdata_i (HWDATA),
    .rdata_o (ram_rdata)
  );

  assign HRDATA      = (state_q == S_RD) ? ram_rdata : hold_q;
  assign HREADYOUT   = (state_q != S_RD_STALL) && (state_q != S_ERR1);
  assign HRESP       = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR
                                                                    : HRESP_OKAY;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_lite_bram_slave.sv
module tb_ahb_lite_bram_slave;

  localparam int BW = 14;
  localparam logic [1:0] T_IDL = 2'b00;
  localparam logic [1:0] T_BSY = 2'b01;
  localparam logic [1:0] T_NSQ = 2'b10;
  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;
  localparam logic [63:0] D1 = 64'h1122334455667788;
  localparam logic [63:0] D2 = 64'h11223344AB667788;
  localparam logic [63:0] D3 = 64'h89ABCDEF01234567;
  localparam logic [31:0] ALIAS_ADDR = 32'h1 << (BW + 3);

  // Expected entry: {hreadyout, hresp, check_rdata, rdata}
  localparam int W = 67;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [63:0] hwdata;
  logic        hready;
  logic [63:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic [2:0]  dbg_state;

  assign hready = hreadyout;

  ahb_lite_bram_slave #(.BRAM_WIDTH(BW), .INIT_FILE("")) dut (
    .clk         (clk),
    .reset       (reset),
    .HSEL        (hsel),
    .HADDR       (haddr),
    .HTRANS      (htrans),
    .HWRITE      (hwrite),
    .HSIZE       (hsize),
    .HBURST      (hburst),
    .HWDATA      (hwdata),
    .HREADY      (hready),
    .HRDATA      (hrdata),
    .HREADYOUT   (hreadyout),
    .HRESP       (hresp),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cyc++;
      n_tests++;
      if (hreadyout !== e[66]) begin
        n_fail++;
        $display("FAIL hreadyout cycle %0d: got %b expected %b", n_cyc, hreadyout, e[66]);
      end
      n_tests++;
      if (hresp !== e[65]) begin
        n_fail++;
        $display("FAIL hresp cycle %0d: got %b expected %b", n_cyc, hresp, e[65]);
      end
      if (e[64]) begin
        n_tests++;
        if (hrdata !== e[63:0]) begin
          n_fail++;
          $display("FAIL hrdata cycle %0d: got %h expected %h", n_cyc, hrdata, e[63:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Drives one bus cycle (address-phase fields plus the HWDATA of whatever
  // data phase is open) and queues the outputs expected during that cycle.
  task automatic cyc(input logic rst, input logic sel, input logic [1:0] trans,
                     input logic wr, input logic [2:0] size, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic rdy, input logic resp,
                     input logic chk, input logic [63:0] data);
    reset  = rst;
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
    hwdata = wdata;
    exp_q.push_back({rdy, resp, chk, data});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hsel = 1'b0; haddr = '0; htrans = T_IDL; hwrite = 1'b0;
    hsize = SZ_B; hburst = 3'd0; hwdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    //   rst sel trans  wr size  addr        wdata                    rdy rsp chk data
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, 64'h0); // reset state
    // DWORD write then (after idle) DWORD read, zero wait
    cyc(0, 1, T_NSQ, 1, SZ_D, 32'h10,     64'h0,                    1, 0, 1, 64'h0);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      D1,                       1, 0, 1, 64'h0);
    cyc(0, 1, T_NSQ, 0, SZ_D, 32'h10,     64'h0,                    1, 0, 1, 64'h0);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, D1);
    // BYTE write to lane 3, read immediately after: one wait state
    cyc(0, 1, T_NSQ, 1, SZ_B, 32'h13,     64'h0,                    1, 0, 1, D1);
    cyc(0, 1, T_NSQ, 0, SZ_D, 32'h10,     64'h00000000AB000000,     1, 0, 1, D1);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    0, 0, 1, D1);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, D2);
    // misaligned HALF write: two-cycle error, no side effect
    cyc(0, 1, T_NSQ, 1, SZ_H, 32'h11,     64'h0,                    1, 0, 1, D2);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'hFFFFFFFFFFFFFFFF,     0, 1, 0, 64'h0);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 1, 0, 64'h0);
    cyc(0, 1, T_NSQ, 0, SZ_D, 32'h10,     64'h0,                    1, 0, 1, D2);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, D2);
    // HSIZE=4 read: error; NONSEQ during the second error cycle is taken
    cyc(0, 1, T_NSQ, 0, 3'd4, 32'h20,     64'h0,                    1, 0, 1, D2);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    0, 1, 0, 64'h0);
    cyc(0, 1, T_NSQ, 0, SZ_D, 32'h10,     64'h0,                    1, 1, 0, 64'h0);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, D2);
    // pre-write 0x18 with 0, then reset during the data phase of a write
    cyc(0, 1, T_NSQ, 1, SZ_D, 32'h18,     64'h0,                    1, 0, 1, D2);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, D2);
    cyc(0, 1, T_NSQ, 1, SZ_D, 32'h18,     64'h0,                    1, 0, 1, D2);
    cyc(1, 0, T_IDL, 0, SZ_B, 32'h0,      64'hDEAD,                 1, 0, 1, D2);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, 64'h0);
    cyc(0, 1, T_NSQ, 0, SZ_D, 32'h18,     64'h0,                    1, 0, 1, 64'h0);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, 64'h0);
    // aliasing write, read at 0x0, then BUSY is ignored
    cyc(0, 1, T_NSQ, 1, SZ_D, ALIAS_ADDR, 64'h0,                    1, 0, 1, 64'h0);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'hCAFE,                 1, 0, 1, 64'h0);
    cyc(0, 1, T_NSQ, 0, SZ_D, 32'h0,      64'h0,                    1, 0, 1, 64'h0);
    cyc(0, 1, T_BSY, 0, SZ_D, 32'h10,     64'h0,                    1, 0, 1, 64'hCAFE);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, 64'hCAFE);
    // back-to-back WORD writes, then stalled read of the merged word
    cyc(0, 1, T_NSQ, 1, SZ_W, 32'h24,     64'h0,                    1, 0, 1, 64'hCAFE);
    cyc(0, 1, T_NSQ, 1, SZ_W, 32'h20,     64'h89ABCDEF00000000,     1, 0, 1, 64'hCAFE);
    cyc(0, 1, T_NSQ, 0, SZ_D, 32'h20,     64'h0000000001234567,     1, 0, 1, 64'hCAFE);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    0, 0, 1, 64'hCAFE);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, D3);
    cyc(0, 0, T_IDL, 0, SZ_B, 32'h0,      64'h0,                    1, 0, 1, D3);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
